// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 scanout path.
// Optional feature macro used by the top level: VGA_BORDER_EN.
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Side length of the square framebuffer image
  localparam int IMG_SIZE = 256;

  // Per-pixel control bits that travel alongside the memory read
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic img;
    logic ring;
    logic frame_start;
  } pix_ctl_t;

  // Idle/reset value: syncs inactive (high), everything else off
  localparam pix_ctl_t CTL_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    blank_n:     1'b0,
    img:         1'b0,
    ring:        1'b0,
    frame_start: 1'b0
  };

  // True when lo <= val < lo+len
  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with raw (undelayed) sync and active flags.
import vga_pkg::*;

module vga_timing (
  input  logic       clk,
  input  logic       i_rst_n,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_frame_start
);

  logic [9:0] r_h;
  logic [9:0] r_v;

  // Raster position: h wraps at end of line, v advances on each h wrap
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == 10'(H_TOTAL - 1)) begin
      r_h <= '0;
      r_v <= (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_hsync       = !in_window(int'(r_h), H_ACTIVE + H_FP, H_SYNC);
  assign o_vsync       = !in_window(int'(r_v), V_ACTIVE + V_FP, V_SYNC);
  assign o_active      = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign o_frame_start = (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: issues framebuffer reads for a 256x256 grayscale image placed
// at (IMG_X0, IMG_Y0) and realigns syncs/blanking with the returned data.
// Optional macro VGA_BORDER_EN paints a white 1-pixel ring around the image.
import vga_pkg::*;

module vga_scanout #(
  parameter int IMG_X0  = 192,
  parameter int IMG_Y0  = 112,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] pixel_addr,
  output logic        pixel_rd,
  input  logic [7:0]  pixel_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start
);

`ifdef VGA_BORDER_EN
  localparam logic [7:0] RING_COLOUR = 8'hFF;
`else
  localparam logic [7:0] RING_COLOUR = 8'h00;
`endif

  logic [9:0] w_h;
  logic [9:0] w_v;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_active;
  logic       w_frame_start;
  logic       w_in_img;
  logic       w_in_ring;
  logic       w_rd;
  logic [7:0] w_col;
  logic [7:0] w_row;
  pix_ctl_t   w_ctl0;
  pix_ctl_t   w_out;

  logic [15:0] r_addr;
  logic        r_rd;
  pix_ctl_t    r_ctl [0:MEM_LAT];

  vga_timing u_timing (
    .clk           (clk),
    .i_rst_n       (reset),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_active      (w_active),
    .o_frame_start (w_frame_start)
  );

  // Image rectangle and the ring one pixel outside it (ring limited to active area)
  assign w_in_img  = in_window(int'(w_h), IMG_X0, IMG_SIZE) &&
                     in_window(int'(w_v), IMG_Y0, IMG_SIZE);
  assign w_in_ring = w_active && !w_in_img &&
                     in_window(int'(w_h), IMG_X0 - 1, IMG_SIZE + 2) &&
                     in_window(int'(w_v), IMG_Y0 - 1, IMG_SIZE + 2);

  // Only the low 8 bits of the offsets matter: the image is exactly 256 wide/tall
  assign w_col = w_h[7:0] - 8'(IMG_X0);
  assign w_row = w_v[7:0] - 8'(IMG_Y0);
  assign w_rd  = w_in_img & enable;

  assign w_ctl0 = '{
    hsync:       w_hsync,
    vsync:       w_vsync,
    blank_n:     w_active,
    img:         w_rd,
    ring:        w_in_ring & enable,
    frame_start: w_frame_start
  };

  // Address stage: address only moves while reading, so it holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_rd   <= 1'b0;
    end else begin
      r_rd <= w_rd;
      if (w_rd) begin
        r_addr <= {w_row, w_col};
      end
    end
  end

  // First delay stage captures control in the same cycle as the address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctl[0] <= CTL_RESET;
    end else begin
      r_ctl[0] <= w_ctl0;
    end
  end

  // Remaining stages cover the memory read latency
  generate
    for (genvar gi = 1; gi <= MEM_LAT; gi++) begin : g_dly
      // Shift control one stage further toward the output
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ctl[gi] <= CTL_RESET;
        end else begin
          r_ctl[gi] <= r_ctl[gi-1];
        end
      end
    end
  endgenerate

  assign w_out = r_ctl[MEM_LAT];

  assign pixel_addr  = r_addr;
  assign pixel_rd    = r_rd;
  assign hsync       = w_out.hsync;
  assign vsync       = w_out.vsync;
  assign blank_n     = w_out.blank_n;
  assign frame_start = w_out.frame_start;
  assign sync_n      = 1'b1;

  // Grayscale image data fans out to all channels; ring/background otherwise
  assign vga_r = w_out.img ? pixel_data : (w_out.ring ? RING_COLOUR : 8'h00);
  assign vga_g = vga_r;
  assign vga_b = vga_r;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter IMG_X0, default 192, meaning first active column of the 256x256 image.
REQ-002 SHALL have parameter IMG_Y0, default 112, meaning first active line of the image.
REQ-003 SHALL have parameter MEM_LAT, default 1, meaning cycles from pixel_addr to valid pixel_data (range 1..4).
REQ-004 SHALL have port clk, input, 1, pixel clock (25 MHz); the only clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, display enable (board switch).
REQ-007 SHALL have port pixel_addr, output, 16, framebuffer read address.
REQ-008 SHALL have port pixel_rd, output, 1, read strobe, high when pixel_addr is valid.
REQ-009 SHALL have port pixel_data, input, 8, grayscale pixel returned MEM_LAT cycles after pixel_addr.
REQ-010 SHALL have ports vga_r, vga_g, vga_b, output, 8 each, colour channels.
REQ-011 SHALL have ports hsync, vsync, output, 1 each, active-low syncs.
REQ-012 SHALL have ports blank_n, sync_n, output, 1 each, DAC blanking (low outside active area) and composite sync (tied high).
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse marking output pixel (0,0).

Function
REQ-014 Horizontal counter h SHALL count 0..799 and wrap to 0; vertical counter v SHALL increment when h wraps, count 0..524 and wrap to 0.
REQ-015 Active area SHALL be h<640 and v<480; hsync SHALL be low for h 656..751; vsync SHALL be low for v 490..491.
REQ-016 in_img SHALL be true for IMG_X0<=h<IMG_X0+256 and IMG_Y0<=v<IMG_Y0+256.
REQ-017 Stage 1 SHALL register pixel_addr = {(v-IMG_Y0)[7:0], (h-IMG_X0)[7:0]} and pixel_rd = in_img & enable.
REQ-018 When pixel_rd is low, pixel_addr SHALL hold its last value.
REQ-019 hsync, vsync, blank_n, in_img and frame_start SHALL be delayed 1+MEM_LAT cycles, so every output reflects one counter value (h,v).
REQ-020 Outputs SHALL be vga_r=vga_g=vga_b=pixel_data when delayed in_img&enable, else 0x00.
REQ-021 Address SHALL run 0 to 65535 once per frame, 65535 issued at (IMG_X0+255, IMG_Y0+255), with no wrap inside a frame.
REQ-022 Deasserting enable SHALL NOT disturb timing; syncs continue and colour forced 0 starting at the first delayed pixel sampled with enable low.

Reset
REQ-023 While reset is low: h=v=0, pixel_addr=0, pixel_rd=0, colours 0, hsync=vsync=1, blank_n=0, frame_start=0, all delay stages cleared.
REQ-024 Reset asserted mid-frame SHALL abort immediately; after release the frame restarts at (0,0), with the first frame_start 1+MEM_LAT cycles after release.

Configuration
REQ-025 With macro VGA_BORDER_EN defined, pixels on the 1-pixel ring just outside the image (active area only) SHALL output 0xFF on all channels when enable is high; without it, the ring SHALL output 0x00.

Structure
REQ-026 Package vga_pkg SHALL hold the timing constants H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, H_TOTAL, V_TOTAL and IMG_SIZE=256.
REQ-027 Sub-module vga_timing SHALL contain the h/v counters and raw sync/active generation; vga_scanout SHALL contain the address stage and delay line.

Verification
REQ-028 Release reset, enable=1 -> first hsync falling edge 656+1+MEM_LAT cycles after release; first vsync low at line 490, lasting 1600 cycles.
REQ-029 Model memory returns pixel_data=addr[7:0]; at output (IMG_X0+5, IMG_Y0+0) -> rgb=0x05; at (IMG_X0-1, IMG_Y0) -> 0x00 without border.
REQ-030 Full frame -> exactly 65536 pixel_rd cycles, with addresses 0..65535 strictly consecutive.
REQ-031 Drop enable mid-line -> pixel_rd=0, rgb=0x00, and hsync/vsync periods unchanged (800/420000 cycles).
REQ-032 Assert reset at h=300,v=200 -> all outputs at reset values; after release frame_start pulses once per 420000 cycles.
REQ-033 With VGA_BORDER_EN defined -> output (IMG_X0-1, IMG_Y0-1) and (IMG_X0+256, IMG_Y0+100) are 0xFF, and (IMG_X0, IMG_Y0) is memory data.
